// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the cache arbiter state encoding.
// Used by cache_arbiter; behaviour selectable with CACHE_ARBITER_ROUND_ROBIN_EN.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Grant FSM for the I/D cache arbiter: one transaction per grant, IDLE between grants.
// Define CACHE_ARBITER_ROUND_ROBIN_EN for alternating tie-break instead of fixed D priority.
module cache_arbiter_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_icache_req,
    input  logic i_dcache_req,
    input  logic i_pmem_resp,
    output logic grant_i,
    output logic grant_d
);

    arb_state_t r_state;
    arb_state_t w_nextState;
    arb_state_t w_tieState;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    logic r_lastGrantD;

    // Remember who won the most recent grant so a tie goes to the other side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastGrantD <= 1'b0;
        end else if (r_state == IDLE && w_nextState != IDLE) begin
            r_lastGrantD <= (w_nextState == SERVE_D);
        end
    end

    assign w_tieState = r_lastGrantD ? SERVE_I : SERVE_D;
`else
    assign w_tieState = SERVE_D;
`endif

    always_comb begin
        w_nextState = r_state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_dcache_req && i_icache_req) begin
                    w_nextState = w_tieState;
                end else if (i_dcache_req) begin
                    w_nextState = SERVE_D;
                end else if (i_icache_req) begin
                    w_nextState = SERVE_I;
                end
            end
            // A dropped request is an abort and releases the grant like a response.
            SERVE_I: begin
                grant_i = 1'b1;
                if (i_pmem_resp || !i_icache_req) begin
                    w_nextState = IDLE;
                end
            end
            SERVE_D: begin
                grant_d = 1'b1;
                if (i_pmem_resp || !i_dcache_req) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical memory port between the I-cache and D-cache; datapath muxes only.
// CACHE_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break inside cache_arbiter_control.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_pmem_read,
    input  logic [15:0]           icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [15:0]           dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [15:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    logic     w_grantI;
    logic     w_grantD;
    logic     w_dReq;
    lc3b_word w_addr;

    assign w_dReq = dcache_pmem_read | dcache_pmem_write;

    cache_arbiter_control u_control (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_icache_req (icache_pmem_read),
        .i_dcache_req (w_dReq),
        .i_pmem_resp  (pmem_resp),
        .grant_i      (w_grantI),
        .grant_d      (w_grantD)
    );

    // Memory side follows the granted requester; a simultaneous D read+write is a write.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        w_addr     = '0;
        pmem_wdata = '0;
        if (w_grantI) begin
            pmem_read = icache_pmem_read;
            w_addr    = icache_pmem_address;
        end else if (w_grantD) begin
            pmem_read  = dcache_pmem_read & ~dcache_pmem_write;
            pmem_write = dcache_pmem_write;
            w_addr     = dcache_pmem_address;
            pmem_wdata = dcache_pmem_wdata;
        end
    end

    assign pmem_address = w_addr;

    assign icache_pmem_resp  = w_grantI & pmem_resp;
    assign dcache_pmem_resp  = w_grantD & pmem_resp;
    assign icache_pmem_rdata = w_grantI ? pmem_rdata : '0;
    assign dcache_pmem_rdata = w_grantD ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios then random traffic vs a grant-owner model.
// Expectations follow CACHE_ARBITER_ROUND_ROBIN_EN when the bench is compiled with it.
module tb_cache_arbiter;

    localparam int LW = 128;

    logic          clk;
    logic          rstN;
    logic          iRd;
    logic [15:0]   iAddr;
    logic [LW-1:0] iRdata;
    logic          iResp;
    logic          dRd;
    logic          dWr;
    logic [15:0]   dAddr;
    logic [LW-1:0] dWdata;
    logic [LW-1:0] dRdata;
    logic          dResp;
    logic          mRd;
    logic          mWr;
    logic [15:0]   mAddr;
    logic [LW-1:0] mWdata;
    logic [LW-1:0] mRdata;
    logic          mResp;

    int    nChecks = 0;
    int    nFail   = 0;
    string stepName = "reset";

    // Model: who currently owns the memory port (0 = nobody, 1 = I-cache, 2 = D-cache)
    int owner = 0;
    bit lastWasD = 1'b0;

    cache_arbiter #(.LINE_WIDTH(LW)) dut (
        .clk                 (clk),
        .rst_n               (rstN),
        .icache_pmem_read    (iRd),
        .icache_pmem_address (iAddr),
        .icache_pmem_rdata   (iRdata),
        .icache_pmem_resp    (iResp),
        .dcache_pmem_read    (dRd),
        .dcache_pmem_write   (dWr),
        .dcache_pmem_address (dAddr),
        .dcache_pmem_wdata   (dWdata),
        .dcache_pmem_rdata   (dRdata),
        .dcache_pmem_resp    (dResp),
        .pmem_read           (mRd),
        .pmem_write          (mWr),
        .pmem_address        (mAddr),
        .pmem_wdata          (mWdata),
        .pmem_rdata          (mRdata),
        .pmem_resp           (mResp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s/%s observed=%h expected=%h", stepName, tag, obs, exp);
        end
    endtask

    // Expected outputs derived directly from who owns the port this cycle.
    task automatic checkOutput();
        logic          eRd, eWr, eIResp, eDResp;
        logic [15:0]   eAddr;
        logic [LW-1:0] eWdata, eIRdata, eDRdata;
        eRd = 0; eWr = 0; eIResp = 0; eDResp = 0;
        eAddr = '0; eWdata = '0; eIRdata = '0; eDRdata = '0;
        if (owner == 1) begin
            eRd = iRd; eAddr = iAddr; eIResp = mResp; eIRdata = mRdata;
        end else if (owner == 2) begin
            eRd = dRd && !dWr; eWr = dWr; eAddr = dAddr; eWdata = dWdata;
            eDResp = mResp; eDRdata = mRdata;
        end
        chk("pmem_read",   LW'(mRd),    LW'(eRd));
        chk("pmem_write",  LW'(mWr),    LW'(eWr));
        chk("pmem_addr",   LW'(mAddr),  LW'(eAddr));
        chk("pmem_wdata",  mWdata,      eWdata);
        chk("i_resp",      LW'(iResp),  LW'(eIResp));
        chk("i_rdata",     iRdata,      eIRdata);
        chk("d_resp",      LW'(dResp),  LW'(eDResp));
        chk("d_rdata",     dRdata,      eDRdata);
    endtask

    task automatic modelEdge();
        bit dWant;
        dWant = dRd || dWr;
        if (!rstN) begin
            owner    = 0;
            lastWasD = 1'b0;
        end else if (owner == 0) begin
            if (dWant && iRd) begin
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
                owner = lastWasD ? 1 : 2;
`else
                owner = 2;
`endif
            end else if (dWant) begin
                owner = 2;
            end else if (iRd) begin
                owner = 1;
            end
            if (owner != 0) lastWasD = (owner == 2);
        end else if (owner == 1) begin
            if (mResp || !iRd) owner = 0;
        end else begin
            if (mResp || !dWant) owner = 0;
        end
    endtask

    // Set request/response inputs, check this cycle, then advance one clock.
    task automatic applyStimulus(input logic ir, input logic dr, input logic dw, input logic rsp);
        iRd = ir; dRd = dr; dWr = dw; mResp = rsp;
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge();
        #2;
    endtask

    task automatic tieRound();
        iAddr = 16'h0040; dAddr = 16'h8000; dWdata = {4{32'hDEAD_BEEF}};
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 1, 0);
        mRdata = {4{32'h1111_2222}};
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 0, 0, 0);
        mRdata = {4{32'h3333_4444}};
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        rstN = 0; iRd = 0; dRd = 0; dWr = 0; mResp = 0;
        iAddr = '0; dAddr = '0; dWdata = '0; mRdata = '0;
        @(posedge clk);
        modelEdge();
        #2;
        applyStimulus(0, 0, 0, 0);
        rstN = 1;

        stepName = "idle_resp_ignored";
        mRdata = {4{32'hCAFE_F00D}};
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        stepName = "tie_first";
        iAddr = 16'h0040; dAddr = 16'h8000; dWdata = {4{32'hDEAD_BEEF}};
        applyStimulus(1, 0, 1, 0);
        #1;
        chk("first_tie_to_d", LW'(mWr), LW'(1'b1));
        chk("first_tie_addr", LW'(mAddr), LW'(16'h8000));
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        stepName = "tie_rounds";
        for (int r = 0; r < 4; r++) tieRound();

        stepName = "i_read_1230";
        iAddr = 16'h1230; mRdata = {16{8'hA5}};
        applyStimulus(1, 0, 0, 0);
        for (int c = 1; c < 4; c++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        stepName = "d_read_i_held";
        dAddr = 16'h2000; iAddr = 16'h0100; mRdata = {4{32'h5A5A_0F0F}};
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        stepName = "reset_mid_serve_i";
        iAddr = 16'h0777;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        rstN = 0;
        applyStimulus(1, 0, 0, 0);
        rstN = 1;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        stepName = "d_rw_both_abort";
        dAddr = 16'h4000; dWdata = {4{32'h0BAD_CAFE}};
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        stepName = "random";
        for (int c = 0; c < 400; c++) begin
            iAddr  = 16'($urandom);
            dAddr  = 16'($urandom);
            dWdata = {$urandom, $urandom, $urandom, $urandom};
            mRdata = {$urandom, $urandom, $urandom, $urandom};
            rstN   = ($urandom % 64) != 0;
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0,
                          ($urandom % 4) == 0, ($urandom % 3) == 0);
        end
        rstN = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
